// File: rtl/load_store_unit.sv
// Data-memory initiator for loads and stores.
// Takes one request per handshake and issues word-aligned beats with byte enables.
// An access that crosses a word boundary is split into two beats.
// Load data is reassembled from the beat words, then sign- or zero-extended.
// Every accepted request gets exactly one response pulse; illegal funct3 codes return an error.
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [DM_ADDRESS-1:0] mem_addr_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE0 = 3'd1,
        S_ISSUE1 = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                state_q;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic                  split_q;
    logic [7:0]            mask_q;
    logic [63:0]           wd_q;
    logic [DM_ADDRESS-1:0] w0_q;
    logic [31:0]           lo_q;

    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;
    logic [DM_ADDRESS-1:0] mem_addr_q;
    logic                  mem_re_q;
    logic                  mem_we_q;
    logic [3:0]            mem_be_q;
    logic [31:0]           mem_wdata_q;

    // Address bits above the data-memory window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[DATA_W-1:DM_ADDRESS];

    logic                  acc_fire;
    logic [1:0]            acc_off;
    logic [2:0]            acc_size;
    logic [7:0]            acc_lanes;
    logic [7:0]            acc_mask;
    logic [63:0]           acc_wd;
    logic                  acc_split;
    logic                  acc_illegal;
    logic [DM_ADDRESS-1:0] acc_w0;

    // Lane mask, shifted store data and split decision for the incoming request.
    always_comb begin
        acc_fire = req_valid_i && req_ready_q;
        acc_off  = req_addr_i[1:0];
        case (req_funct3_i[1:0])
            2'b00:   begin acc_size = 3'd1; acc_lanes = 8'h01; end
            2'b01:   begin acc_size = 3'd2; acc_lanes = 8'h03; end
            default: begin acc_size = 3'd4; acc_lanes = 8'h0F; end
        endcase
        acc_mask    = acc_lanes << acc_off;
        acc_wd      = {32'h0, req_wdata_i} << {acc_off, 3'b000};
        acc_split   = ({1'b0, acc_off} + acc_size) > 3'd4;
        acc_illegal = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                      (req_funct3_i == 3'b111);
        acc_w0      = {req_addr_i[DM_ADDRESS-1:2], 2'b00};
    end

    logic [63:0] asm_pair;
    logic [31:0] asm_raw;
    logic [31:0] asm_ext;

    // Reassemble the final load word from the buffered low word and the arriving word, then extend.
    always_comb begin
        asm_pair = split_q ? {mem_rdata_i, lo_q} : {32'h0, mem_rdata_i};
        asm_raw  = 32'(asm_pair >> {off_q, 3'b000});
        case (funct3_q)
            3'b000:  asm_ext = {{24{asm_raw[7]}}, asm_raw[7:0]};
            3'b001:  asm_ext = {{16{asm_raw[15]}}, asm_raw[15:0]};
            3'b100:  asm_ext = {24'h0, asm_raw[7:0]};
            3'b101:  asm_ext = {16'h0, asm_raw[15:0]};
            default: asm_ext = asm_raw;
        endcase
    end

    // Control FSM; every output is registered and set on entry to the state that drives it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            split_q     <= 1'b0;
            mask_q      <= 8'h00;
            wd_q        <= 64'h0;
            w0_q        <= '0;
            lo_q        <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (acc_fire) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we_i;
                        funct3_q    <= req_funct3_i;
                        off_q       <= acc_off;
                        split_q     <= acc_split;
                        mask_q      <= acc_mask;
                        wd_q        <= acc_wd;
                        w0_q        <= acc_w0;
                        lo_q        <= 32'h0;
                        if (acc_illegal) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q     <= S_ISSUE0;
                            mem_addr_q  <= acc_w0;
                            mem_re_q    <= !req_we_i;
                            mem_we_q    <= req_we_i;
                            mem_be_q    <= req_we_i ? acc_mask[3:0] : 4'h0;
                            mem_wdata_q <= req_we_i ? acc_wd[31:0] : 32'h0;
                        end
                    end
                end
                S_ISSUE0: begin
                    if (split_q) begin
                        // Second beat goes to the following word, wrapping at the top of memory.
                        state_q     <= S_ISSUE1;
                        mem_addr_q  <= w0_q + DM_ADDRESS'(4);
                        mem_be_q    <= we_q ? mask_q[7:4] : 4'h0;
                        mem_wdata_q <= we_q ? wd_q[63:32] : 32'h0;
                    end else begin
                        mem_addr_q  <= '0;
                        mem_re_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'h0;
                        mem_wdata_q <= 32'h0;
                        if (we_q) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            rsp_err_q   <= 1'b0;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_ISSUE1: begin
                    // The word read by the first beat is on mem_rdata now.
                    if (!we_q) begin
                        lo_q <= mem_rdata_i;
                    end
                    mem_addr_q  <= '0;
                    mem_re_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_be_q    <= 4'h0;
                    mem_wdata_q <= 32'h0;
                    if (we_q) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= asm_ext;
                    rsp_err_q   <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_re_o    = mem_re_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a simple one-cycle-latency word memory.
module tb_load_store_unit;

    logic        clk_i;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [8:0]  mem_addr_o;
    logic        mem_re_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_re_o     (mem_re_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Word memory: read data valid one cycle after mem_re, byte-enabled writes, bench preload port.
    logic [31:0] mem [0:127];
    logic        pl_we = 1'b0;
    logic [6:0]  pl_idx = 7'd0;
    logic [31:0] pl_data = 32'h0;

    always @(posedge clk_i) begin
        if (pl_we) mem[pl_idx] <= pl_data;
        if (mem_re_o) mem_rdata_i <= mem[mem_addr_o[8:2]];
        if (mem_we_o) begin
            for (int i = 0; i < 4; i++)
                if (mem_be_o[i]) mem[mem_addr_o[8:2]][8*i +: 8] <= mem_wdata_o[8*i +: 8];
        end
    end

    int checks   = 0;
    int failures = 0;

    // Per-transaction observations, cycle k=1 is the cycle after the accepting edge.
    int          nbeats;
    int          b_k     [4];
    logic [8:0]  b_addr  [4];
    logic        b_re    [4];
    logic        b_we    [4];
    logic [3:0]  b_be    [4];
    logic [31:0] b_wdata [4];
    int          rsp_cnt;
    int          rsp_k;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    int          overlap;
    logic        acc_ready;
    logic        ready_k [8];

    task automatic preload(input logic [8:0] byte_addr, input logic [31:0] data);
        @(negedge clk_i);
        pl_idx  = byte_addr[8:2];
        pl_data = data;
        pl_we   = 1'b1;
        @(negedge clk_i);
        pl_we   = 1'b0;
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        nbeats = 0; rsp_cnt = 0; rsp_k = 0; rsp_rdata = 32'h0; rsp_err = 1'b0; overlap = 0;
        for (int i = 0; i < 8; i++) ready_k[i] = 1'b0;
        @(negedge clk_i);
        acc_ready    = req_ready_o;
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_i);
            ready_k[k] = req_ready_o;
            if (mem_re_o && mem_we_o) overlap++;
            if ((mem_re_o || mem_we_o) && nbeats < 4) begin
                b_k[nbeats]     = k;
                b_addr[nbeats]  = mem_addr_o;
                b_re[nbeats]    = mem_re_o;
                b_we[nbeats]    = mem_we_o;
                b_be[nbeats]    = mem_be_o;
                b_wdata[nbeats] = mem_wdata_o;
                nbeats++;
            end
            if (rsp_valid_o) begin
                rsp_cnt++;
                rsp_k     = k;
                rsp_rdata = rsp_rdata_o;
                rsp_err   = rsp_err_o;
            end
        end
        $display("txn we=%0d f3=%03b addr=%08h wdata=%08h beats=%0d rsp@%0d rdata=%08h err=%0d",
                 we, f3, addr, wd, nbeats, rsp_k, rsp_rdata, rsp_err);
    endtask

    task automatic test_reset();
        reset_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
        req_funct3_i = 3'b000; req_addr_i = 32'h0; req_wdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_o); end
        checks++; if ({mem_re_o, mem_we_o, mem_be_o} !== 6'b0) begin failures++; $display("FAIL reset_strobes got=%b%b%b exp=0", mem_re_o, mem_we_o, mem_be_o); end
        checks++; if (mem_addr_o !== 9'h0 || mem_wdata_o !== 32'h0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin
            failures++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h err=%b exp all 0", mem_addr_o, mem_wdata_o, rsp_rdata_o, rsp_err_o); end
    endtask

    task automatic test_load_word();
        run_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        checks++; if (acc_ready !== 1'b1) begin failures++; $display("FAIL lw_ready got=%b exp=1", acc_ready); end
        checks++; if (nbeats !== 1) begin failures++; $display("FAIL lw_nbeats got=%0d exp=1", nbeats); end
        checks++; if (b_k[0] !== 1 || b_addr[0] !== 9'h010 || b_re[0] !== 1'b1 || b_we[0] !== 1'b0 || b_be[0] !== 4'h0) begin
            failures++; $display("FAIL lw_beat k=%0d addr=%h re=%b we=%b be=%b exp k=1 addr=010 re=1 we=0 be=0000", b_k[0], b_addr[0], b_re[0], b_we[0], b_be[0]); end
        checks++; if (rsp_cnt !== 1 || rsp_k !== 3) begin failures++; $display("FAIL lw_rsp_timing cnt=%0d k=%0d exp cnt=1 k=3", rsp_cnt, rsp_k); end
        checks++; if (rsp_rdata !== 32'h8877_6655 || rsp_err !== 1'b0) begin failures++; $display("FAIL lw_rdata got=%h err=%b exp=88776655 err=0", rsp_rdata, rsp_err); end
    endtask

    task automatic test_load_sub();
        run_req(1'b0, 3'b000, 32'h0000_0013, 32'h0);
        checks++; if (rsp_rdata !== 32'hFFFF_FF88 || rsp_k !== 3) begin failures++; $display("FAIL lb got=%h k=%0d exp=ffffff88 k=3", rsp_rdata, rsp_k); end
        run_req(1'b0, 3'b100, 32'h0000_0013, 32'h0);
        checks++; if (rsp_rdata !== 32'h0000_0088) begin failures++; $display("FAIL lbu got=%h exp=00000088", rsp_rdata); end
        run_req(1'b0, 3'b101, 32'h0000_0012, 32'h0);
        checks++; if (rsp_rdata !== 32'h0000_8877) begin failures++; $display("FAIL lhu got=%h exp=00008877", rsp_rdata); end
        run_req(1'b0, 3'b001, 32'h0000_0012, 32'h0);
        checks++; if (rsp_rdata !== 32'hFFFF_8877) begin failures++; $display("FAIL lh got=%h exp=ffff8877", rsp_rdata); end
        run_req(1'b0, 3'b000, 32'h0000_0011, 32'h0);
        checks++; if (rsp_rdata !== 32'h0000_0066 || nbeats !== 1) begin failures++; $display("FAIL lb_pos got=%h beats=%0d exp=00000066 beats=1", rsp_rdata, nbeats); end
    endtask

    task automatic test_split_load();
        run_req(1'b0, 3'b010, 32'h0000_0012, 32'h0);
        checks++; if (nbeats !== 2) begin failures++; $display("FAIL slw_nbeats got=%0d exp=2", nbeats); end
        checks++; if (b_addr[0] !== 9'h010 || b_k[0] !== 1 || b_addr[1] !== 9'h014 || b_k[1] !== 2 || b_re[1] !== 1'b1) begin
            failures++; $display("FAIL slw_beats a0=%h k0=%0d a1=%h k1=%0d re1=%b exp 010@1 014@2 re", b_addr[0], b_k[0], b_addr[1], b_k[1], b_re[1]); end
        checks++; if (rsp_k !== 4 || rsp_rdata !== 32'hAA99_8877) begin failures++; $display("FAIL slw_rsp k=%0d rdata=%h exp k=4 aa998877", rsp_k, rsp_rdata); end
        run_req(1'b0, 3'b101, 32'h0000_0013, 32'h0);
        checks++; if (nbeats !== 2 || rsp_k !== 4 || rsp_rdata !== 32'h0000_9988) begin
            failures++; $display("FAIL slhu beats=%0d k=%0d rdata=%h exp 2 4 00009988", nbeats, rsp_k, rsp_rdata); end
    endtask

    task automatic test_store_aligned();
        run_req(1'b1, 3'b010, 32'h0000_0018, 32'hDEAD_BEEF);
        checks++; if (nbeats !== 1 || b_we[0] !== 1'b1 || b_re[0] !== 1'b0 || b_be[0] !== 4'hF || b_addr[0] !== 9'h018 || b_wdata[0] !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL sw_beat n=%0d we=%b re=%b be=%b addr=%h wd=%h exp 1 1 0 1111 018 deadbeef", nbeats, b_we[0], b_re[0], b_be[0], b_addr[0], b_wdata[0]); end
        checks++; if (rsp_k !== 2 || rsp_cnt !== 1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL sw_rsp k=%0d cnt=%0d rdata=%h err=%b exp k=2 cnt=1 0 0", rsp_k, rsp_cnt, rsp_rdata, rsp_err); end
        run_req(1'b1, 3'b000, 32'h0000_0019, 32'h0000_00AB);
        checks++; if (b_be[0] !== 4'b0010 || b_wdata[0] !== 32'h0000_AB00) begin failures++; $display("FAIL sb_lane be=%b wd=%h exp 0010 0000ab00", b_be[0], b_wdata[0]); end
        run_req(1'b0, 3'b010, 32'h0000_0018, 32'h0);
        checks++; if (rsp_rdata !== 32'hDEAD_ABEF) begin failures++; $display("FAIL sb_readback got=%h exp=deadabef", rsp_rdata); end
    endtask

    task automatic test_split_store();
        run_req(1'b1, 3'b001, 32'h0000_0013, 32'h0000_1234);
        checks++; if (nbeats !== 2) begin failures++; $display("FAIL ssh_nbeats got=%0d exp=2", nbeats); end
        checks++; if (b_addr[0] !== 9'h010 || b_be[0] !== 4'b1000 || b_wdata[0] !== 32'h3400_0000 || b_k[0] !== 1) begin
            failures++; $display("FAIL ssh_beat0 addr=%h be=%b wd=%h k=%0d exp 010 1000 34000000 1", b_addr[0], b_be[0], b_wdata[0], b_k[0]); end
        checks++; if (b_addr[1] !== 9'h014 || b_be[1] !== 4'b0001 || b_wdata[1] !== 32'h0000_0012 || b_k[1] !== 2 || b_we[1] !== 1'b1) begin
            failures++; $display("FAIL ssh_beat1 addr=%h be=%b wd=%h k=%0d we=%b exp 014 0001 00000012 2 1", b_addr[1], b_be[1], b_wdata[1], b_k[1], b_we[1]); end
        checks++; if (rsp_k !== 3 || overlap !== 0) begin failures++; $display("FAIL ssh_rsp k=%0d overlap=%0d exp k=3 overlap=0", rsp_k, overlap); end
        run_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        checks++; if (rsp_rdata !== 32'h3477_6655) begin failures++; $display("FAIL ssh_rb0 got=%h exp=34776655", rsp_rdata); end
        run_req(1'b0, 3'b010, 32'h0000_0014, 32'h0);
        checks++; if (rsp_rdata !== 32'hCCBB_AA12) begin failures++; $display("FAIL ssh_rb1 got=%h exp=ccbbaa12", rsp_rdata); end
    endtask

    task automatic test_wrap();
        preload(9'h1FC, 32'h4433_2211);
        preload(9'h000, 32'h8877_6655);
        run_req(1'b0, 3'b010, 32'h0000_01FE, 32'h0);
        checks++; if (nbeats !== 2 || b_addr[0] !== 9'h1FC || b_addr[1] !== 9'h000) begin
            failures++; $display("FAIL wrap_beats n=%0d a0=%h a1=%h exp 2 1fc 000", nbeats, b_addr[0], b_addr[1]); end
        checks++; if (rsp_rdata !== 32'h6655_4433 || rsp_k !== 4) begin failures++; $display("FAIL wrap_rdata got=%h k=%0d exp=66554433 k=4", rsp_rdata, rsp_k); end
        // Address bits above the 9-bit window must be ignored.
        run_req(1'b0, 3'b100, 32'hABCD_E1FF, 32'h0);
        checks++; if (nbeats !== 1 || b_addr[0] !== 9'h1FC || rsp_rdata !== 32'h0000_0044) begin
            failures++; $display("FAIL high_addr n=%0d a0=%h rdata=%h exp 1 1fc 00000044", nbeats, b_addr[0], rsp_rdata); end
    endtask

    task automatic test_illegal();
        logic [2:0] codes [3];
        codes[0] = 3'b011; codes[1] = 3'b110; codes[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            run_req(i[0], codes[i], 32'h0000_0010, 32'hFFFF_FFFF);
            checks++; if (nbeats !== 0 || rsp_k !== 1 || rsp_cnt !== 1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
                failures++; $display("FAIL illegal_%03b beats=%0d k=%0d cnt=%0d err=%b rdata=%h exp 0 1 1 1 0", codes[i], nbeats, rsp_k, rsp_cnt, rsp_err, rsp_rdata); end
        end
    endtask

    task automatic test_back_to_back();
        run_req(1'b1, 3'b010, 32'h0000_001C, 32'h1122_3344);
        checks++; if (ready_k[1] !== 1'b0 || ready_k[2] !== 1'b0 || ready_k[3] !== 1'b1) begin
            failures++; $display("FAIL b2b_store_ready k1=%b k2=%b k3=%b exp 0 0 1", ready_k[1], ready_k[2], ready_k[3]); end
        run_req(1'b0, 3'b111, 32'h0, 32'h0);
        checks++; if (acc_ready !== 1'b1 || ready_k[1] !== 1'b0 || ready_k[2] !== 1'b1) begin
            failures++; $display("FAIL b2b_err_ready acc=%b k1=%b k2=%b exp 1 0 1", acc_ready, ready_k[1], ready_k[2]); end
        run_req(1'b0, 3'b010, 32'h0000_001C, 32'h0);
        checks++; if (rsp_rdata !== 32'h1122_3344 || rsp_err !== 1'b0) begin failures++; $display("FAIL b2b_readback got=%h err=%b exp=11223344 0", rsp_rdata, rsp_err); end
    endtask

    task automatic test_reset_mid();
        int spurious;
        int not_ready;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
        req_addr_i = 32'h0000_001E; req_wdata_i = 32'hCAFE_F00D;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++; if (mem_we_o !== 1'b1 || mem_addr_o !== 9'h020 || mem_be_o !== 4'b0011) begin
            failures++; $display("FAIL rst_mid_beat1 we=%b addr=%h be=%b exp 1 020 0011", mem_we_o, mem_addr_o, mem_be_o); end
        #1 reset_i = 1'b1;
        #1;
        checks++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'h0 || req_ready_o !== 1'b1) begin
            failures++; $display("FAIL rst_mid_async we=%b be=%b ready=%b exp 0 0000 1", mem_we_o, mem_be_o, req_ready_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        spurious = 0; not_ready = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (rsp_valid_o) spurious++;
            if (!req_ready_o) not_ready++;
        end
        $display("txn reset during split store, rsp pulses after release=%0d", spurious);
        checks++; if (spurious !== 0 || not_ready !== 0) begin
            failures++; $display("FAIL rst_mid_after rsp_pulses=%0d not_ready=%0d exp 0 0", spurious, not_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        preload(9'h010, 32'h8877_6655);
        preload(9'h014, 32'hCCBB_AA99);
        test_load_word();
        test_load_sub();
        test_split_load();
        test_store_aligned();
        test_split_store();
        test_wrap();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
